// File: rtl/bus_ctrl.sv
// bus_ctrl: CPU data-bus controller serving a synchronous SRAM with fixed wait states and a memory-mapped IO port.
// Defining BUSCTRL_IO_TIMEOUT_EN adds an IO acknowledge timeout with a sticky bus_err flag.
module bus_ctrl #(
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int MEM_WAIT       = 1,
  parameter int IO_TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [31:0]               db_addr,
  input  logic [31:0]               db_dataOut,
  input  logic                      db_re,
  input  logic                      db_we,
  input  logic                      db_io,
  output logic [31:0]               db_dataIn,
  output logic                      db_ready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_en,
  output logic                      mem_we,
  input  logic [31:0]               mem_rdata,
  output logic [31:0]               io_addr,
  output logic [31:0]               io_wdata,
  output logic                      io_re,
  output logic                      io_we,
  input  logic [31:0]               io_rdata,
  input  logic                      io_ack,
  output logic                      bus_err,
  output logic [2:0]                dbg_state_o
);

  // Handshake: the CPU holds db_re/db_we until the one-cycle db_ready strobe and
  // drops or changes them afterwards; io_re/io_we stay stable until io_ack is seen in IO_REQ.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_ACC  = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_IO_REQ   = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  localparam bit        HAS_WAIT  = (MEM_WAIT > 0);
  localparam logic [3:0] WAIT_LAST = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] io_rdata_q, io_rdata_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_err_q, bus_err_d;
  logic        req;
  logic        io_timeout;

  assign req = db_re | db_we;

`ifdef BUSCTRL_IO_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  // Counter holds at the limit; it is cleared whenever the FSM is outside IO_REQ.
  assign io_timeout = (to_cnt_q == 16'(IO_TIMEOUT));

  always_comb begin
    to_cnt_d = 16'd0;
    if (state_q == S_IO_REQ) begin
      to_cnt_d = io_timeout ? to_cnt_q : to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      to_cnt_q <= 16'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_io_timeout_cfg;
  assign io_timeout            = 1'b0;
  assign unused_io_timeout_cfg = ^(32'(IO_TIMEOUT));
`endif

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = db_io ? S_IO_REQ : S_MEM_ACC;
        end
      end
      S_MEM_ACC:  state_d = HAS_WAIT ? S_MEM_WAIT : S_RESP;
      S_MEM_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
        end
      end
      S_IO_REQ: begin
        if (io_ack || io_timeout) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latches, wait counter, IO read latch and sticky error
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    io_d       = io_q;
    io_rdata_d = io_rdata_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d     = db_addr;
          wdata_d    = db_dataOut;
          we_d       = db_we;
          io_d       = db_io;
          io_rdata_d = 32'h0;
        end
      end
      S_MEM_ACC:  wait_cnt_d = 4'd0;
      S_MEM_WAIT: wait_cnt_d = wait_cnt_q + 4'd1;
      S_IO_REQ: begin
        // A late ack in the expiry cycle still completes the access normally.
        if (io_ack) begin
          io_rdata_d = io_rdata;
        end else if (io_timeout) begin
          io_rdata_d = 32'hFFFF_FFFF;
          bus_err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      io_q       <= 1'b0;
      io_rdata_q <= 32'h0;
      wait_cnt_q <= 4'd0;
      bus_err_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      io_q       <= io_d;
      io_rdata_q <= io_rdata_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Output decode
  always_comb begin
    db_ready    = 1'b0;
    db_dataIn   = 32'h0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_q[MEM_ADDR_WIDTH+1:2];
    mem_wdata   = wdata_q;
    io_addr     = addr_q;
    io_wdata    = wdata_q;
    io_re       = 1'b0;
    io_we       = 1'b0;
    bus_err     = bus_err_q;
    dbg_state_o = state_q;
    case (state_q)
      S_MEM_ACC: begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
      S_IO_REQ: begin
        io_re = ~we_q;
        io_we = we_q;
      end
      S_RESP: begin
        db_ready = 1'b1;
        if (!we_q) begin
          db_dataIn = io_q ? io_rdata_q : mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Bench for bus_ctrl: SRAM/IO environment models, a word-level reference memory, and latency/data scoreboard.
// Expectations adapt to BUSCTRL_IO_TIMEOUT_EN being defined or not.
module tb_bus_ctrl;

  localparam int AW    = 14;
  localparam int WAIT  = 2;
  localparam int TMO   = 8;
  localparam int LIMIT = 40;
`ifdef BUSCTRL_IO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic [31:0]   db_addr = '0, db_dataOut = '0, db_dataIn;
  logic          db_re = 1'b0, db_we = 1'b0, db_io = 1'b0, db_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata = '0;
  logic          mem_en, mem_we;
  logic [31:0]   io_addr, io_wdata, io_rdata = '0;
  logic          io_re, io_we, io_ack = 1'b0;
  logic          bus_err;
  logic [2:0]    unused_dbg_state;

  bus_ctrl #(.MEM_ADDR_WIDTH(AW), .MEM_WAIT(WAIT), .IO_TIMEOUT(TMO)) dut (
    .clk(clk), .res(res),
    .db_addr(db_addr), .db_dataOut(db_dataOut), .db_re(db_re), .db_we(db_we), .db_io(db_io),
    .db_dataIn(db_dataIn), .db_ready(db_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_re(io_re), .io_we(io_we),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .bus_err(bus_err), .dbg_state_o(unused_dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM environment: data valid the cycle after mem_en, held otherwise.
  logic [31:0] sram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[int'(mem_addr)] = mem_wdata;
      else        mem_rdata <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 32'h0;
    end
  end

  // Reference model and scoreboard state
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q[$];
  logic        exp_bus_err = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          last_ready_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << AW));
  endfunction

  task automatic drop_req();
    db_re = 1'b0;
    db_we = 1'b0;
    db_io = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_db_ready"},  {31'h0, db_ready}, 32'h0);
    check({tag, "_db_dataIn"}, db_dataIn, 32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr), 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_en_we"}, {30'h0, mem_en, mem_we}, 32'h0);
    check({tag, "_io_addr"},   io_addr, 32'h0);
    check({tag, "_io_wdata"},  io_wdata, 32'h0);
    check({tag, "_io_re_we"},  {30'h0, io_re, io_we}, 32'h0);
    check({tag, "_bus_err"},   {31'h0, bus_err}, 32'h0);
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_no_ready"}, {31'h0, db_ready}, 32'h0);
      check({tag, "_no_mem_en"}, {31'h0, mem_en}, 32'h0);
    end
  endtask

  // One CPU access; called at a negedge. d = IO_REQ cycles before io_ack is raised.
  task automatic do_access(input logic we, input logic re, input logic io, input logic [31:0] addr,
                           input logic [31:0] wdata, input int d, input string tag);
    bit          timed_out, seen;
    int          exp_lat, n_io, n_mem, mem_k, n_re, n_we, idx;
    logic [31:0] io_val, exp_data, g_mem_addr, g_mem_wdata, g_io_addr;
    logic        g_mem_we;
    idx       = word_idx(addr);
    io_val    = $urandom;
    timed_out = io && TO_EN && (d > TMO);
    n_io      = timed_out ? TMO + 1 : d + 1;
    exp_lat   = io ? n_io + 1 : 2 + WAIT;
    if (we)      exp_data = 32'h0;
    else if (io) exp_data = timed_out ? 32'hFFFF_FFFF : io_val;
    else         exp_data = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (!io && we) ref_mem[idx] = wdata;
    if (timed_out) exp_bus_err = 1'b1;
    exp_q.push_back(exp_data);
    // Launched during the previous access's strobe: the request is first sampled next cycle.
    if (db_ready) @(negedge clk);
    db_addr = addr; db_dataOut = wdata; db_re = re; db_we = we; db_io = io;
    seen = 1'b0; n_mem = 0; mem_k = 0; n_re = 0; n_we = 0;
    g_mem_addr = '0; g_mem_wdata = '0; g_mem_we = 1'b0; g_io_addr = '0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      io_ack = 1'b0;
      if (db_ready) begin
        seen = 1'b1;
        last_ready_cyc = cyc;
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_data"}, db_dataIn, exp_q.pop_front());
        check({tag, "_io_idle_in_resp"}, {30'h0, io_re, io_we}, 32'h0);
        check({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, exp_bus_err});
        break;
      end
      if (mem_en) begin
        n_mem++;
        if (n_mem == 1) begin
          mem_k = k; g_mem_addr = 32'(mem_addr); g_mem_wdata = mem_wdata; g_mem_we = mem_we;
        end
      end
      if (io_re) n_re++;
      if (io_we) n_we++;
      if (k == 1) g_io_addr = io_addr;
      if (io) begin
        io_ack   = (k == 1 + d);
        io_rdata = io_val;
      end else begin
        io_ack   = 1'($urandom_range(0, 1));
        io_rdata = $urandom;
      end
    end
    io_ack = 1'b0;
    if (!seen) begin
      check({tag, "_ready_within_budget"}, 32'h0, 32'h1);
      void'(exp_q.pop_front());
    end
    check({tag, "_mem_en_pulses"}, 32'(n_mem), io ? 32'h0 : 32'h1);
    check({tag, "_io_re_cycles"}, 32'(n_re), (io && !we) ? 32'(n_io) : 32'h0);
    check({tag, "_io_we_cycles"}, 32'(n_we), (io && we) ? 32'(n_io) : 32'h0);
    if (!io) begin
      check({tag, "_mem_en_cycle"}, 32'(mem_k), 32'h1);
      check({tag, "_mem_addr"}, g_mem_addr, 32'(idx));
      check({tag, "_mem_we"}, {31'h0, g_mem_we}, {31'h0, we});
      if (we) check({tag, "_mem_wdata"}, g_mem_wdata, wdata);
    end else begin
      check({tag, "_io_addr"}, g_io_addr, addr);
    end
  endtask

  initial begin
    int r1, r2, r3, rr, gap, dd;
    logic [31:0] a;
    logic        rio;

    // Reset state
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    res = 1'b0;

    // Write then read through the SRAM path
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'hCAFE_BABE, 0, "mem_wr");
    drop_req();
    @(negedge clk);
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, "mem_rd");

    // Back-to-back reads with db_re held
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, "b2b_0");
    r1 = last_ready_cyc;
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, "b2b_1");
    r2 = last_ready_cyc;
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0048, 32'h0, 0, "b2b_2");
    r3 = last_ready_cyc;
    check("b2b_period_1", 32'(r2 - r1), 32'(3 + WAIT));
    check("b2b_period_2", 32'(r3 - r2), 32'(3 + WAIT));
    drop_req();
    idle_check(3, "b2b_after");

    // IO read acknowledged in the fifth IO_REQ cycle
    do_access(1'b0, 1'b1, 1'b1, 32'hBFD0_0004, 32'h0, 4, "io_rd");
    drop_req();
    @(negedge clk);

    // Read+write together is a write; upper address bits alias
    do_access(1'b1, 1'b1, 1'b0, 32'h0001_0004, 32'h1357_9BDF, 0, "prio_alias");
    drop_req();
    @(negedge clk);
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 0, "alias_rd");
    drop_req();
    @(negedge clk);

    // IO write with no ack (timeout when enabled, long wait otherwise)
    dd = TO_EN ? 1000 : 20;
    do_access(1'b1, 1'b0, 1'b1, 32'hBFD0_0010, 32'hDEAD_0001, dd, "io_noack");
    drop_req();
    @(negedge clk);
    // Ack in the very cycle the count expires completes normally
    do_access(1'b0, 1'b1, 1'b1, 32'hBFD0_0014, 32'h0, TMO, "io_ack_at_limit");
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, "err_sticky_mem");
    drop_req();
    @(negedge clk);

    // Reset during MEM_WAIT after the SRAM write was issued
    db_we = 1'b1; db_re = 1'b0; db_io = 1'b0; db_addr = 32'h0000_0080; db_dataOut = 32'h5A5A_1234;
    @(negedge clk);
    check("rstmid_mem_en", {31'h0, mem_en}, 32'h1);
    @(negedge clk);
    ref_mem[word_idx(32'h0000_0080)] = 32'h5A5A_1234;
    res = 1'b1;
    #1;
    check_zero("rstmid");
    drop_req();
    exp_bus_err = 1'b0;
    @(negedge clk);
    res = 1'b0;
    idle_check(5, "rstmid_idle");
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, "rstmid_rd");

    // Randomized mix of SRAM and IO accesses
    for (int i = 0; i < 40; i++) begin
      rio = ($urandom_range(0, 3) == 0);
      rr  = $urandom_range(1, 3);
      dd  = $urandom_range(0, 12);
      if (rio) a = $urandom;
      else     a = (32'($urandom_range(0, 7)) << 16) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      do_access(rr[1], rr[0], rio, a, $urandom, dd, "rnd");
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        drop_req();
        repeat (gap) @(negedge clk);
      end
    end
    drop_req();
    idle_check(2, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
